// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register index geometry, shadow-pipeline tag, forward-select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 31;

  // Forward-select encoding seen by the EX operand muxes.
  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  // One in-flight instruction as tracked by the hazard unit's shadow pipeline.
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rd;
  } shadow_tag_t;

endpackage

// File: rtl/fwd_src_match.sv
// One operand source against every shadow entry: nearest-producer select plus load-use flag.
// Latency: purely combinational.
// Backpressure: none; the parent turns the hazard flag into a stall.
//
// Ports:
//   src, src_used  : source register index and its read enable
//   id_valid       : ID slot holds a real instruction
//   shadow         : in-flight tags, entry 0 = EX, deeper entries follow
//   sel            : 0 = register file, k = forward from stage k
//   hazard         : source needs the result of a load sitting in EX
module fwd_src_match
  import cpu_pkg::*;
#(
  parameter int REG_AW     = cpu_pkg::REG_AW,
  parameter int ZERO_REG   = cpu_pkg::ZERO_REG,
  parameter int FWD_STAGES = 2,
  parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic              id_valid,
  input  shadow_tag_t       shadow [FWD_STAGES],
  output logic [SELW-1:0]   sel,
  output logic              hazard
);

  logic [FWD_STAGES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int j = 0; j < FWD_STAGES; j++) begin
      hit[j] = shadow[j].valid & shadow[j].regwrite &
               (shadow[j].rd != REG_AW'(ZERO_REG)) &
               src_used & id_valid & (src == shadow[j].rd);
    end
  end

  // Walk from the deepest entry towards EX so the youngest producer overwrites older ones.
  always_comb begin
    sel = '0;
    for (int j = FWD_STAGES - 1; j >= 0; j--) begin
      if (hit[j]) sel = SELW'(j + 1);
    end
  end

  // Only a load still in EX is too late to forward; deeper loads have their data.
  assign hazard = hit[0] & shadow[0].memread;

  // memread of deeper entries is intentionally ignored here.
  logic unused_deep_memread;
  always_comb begin
    unused_deep_memread = 1'b0;
    for (int j = 1; j < FWD_STAGES; j++) begin
      unused_deep_memread = unused_deep_memread ^ shadow[j].memread;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard unit with its own shadow pipeline of destination tags.
// Latency: fwd_sel registered (decided in ID, valid while the instruction is in EX); stall combinational.
// Backpressure: stall freezes PC/IF-ID for one cycle and the unit inserts the EX bubble itself; hold freezes everything.
//
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   hold, flush                     : global freeze (wins over flush), kill the ID instruction
//   id_valid/regwrite/memread/rd    : tags of the instruction in ID
//   id_src, id_src_used             : NUM_SRC packed source indices and their read enables
//   stall                           : load-use stall request
//   fwd_sel                         : NUM_SRC packed select fields for the EX operand muxes
//   stall_count                     : saturating count of stall cycles
//
// REG_AW must match cpu_pkg::REG_AW because the shadow tag struct is sized by the package.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW     = cpu_pkg::REG_AW,
  parameter int ZERO_REG   = cpu_pkg::ZERO_REG,
  parameter int NUM_SRC    = 3,
  parameter int FWD_STAGES = 2,
  parameter int SELW       = $clog2(FWD_STAGES + 1),
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic                    id_regwrite,
  input  logic                    id_memread,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]      id_src_used,
  output logic                    stall,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic [CNT_W-1:0]        stall_count
);

  shadow_tag_t               shadow [FWD_STAGES];
  shadow_tag_t               id_tag;
  logic [NUM_SRC*SELW-1:0]   next_sel;
  logic [NUM_SRC-1:0]        src_hazard;
  logic                      advance;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .REG_AW    (REG_AW),
      .ZERO_REG  (ZERO_REG),
      .FWD_STAGES(FWD_STAGES),
      .SELW      (SELW)
    ) u_match (
      .src     (id_src[g*REG_AW +: REG_AW]),
      .src_used(id_src_used[g]),
      .id_valid(id_valid),
      .shadow  (shadow),
      .sel     (next_sel[g*SELW +: SELW]),
      .hazard  (src_hazard[g])
    );
  end

  // A flushed ID slot is dead, so it can neither stall nor advance.
  assign stall   = id_valid & ~flush & (|src_hazard);
  assign advance = id_valid & ~flush & ~stall;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = 1'b1;
    id_tag.regwrite = id_regwrite;
    id_tag.memread  = id_memread;
    id_tag.rd       = id_rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < FWD_STAGES; j++) shadow[j] <= '0;
      fwd_sel     <= '0;
      stall_count <= '0;
    end else if (!hold) begin
      // Anything that does not advance out of ID enters EX as a bubble.
      shadow[0] <= advance ? id_tag : '0;
      for (int j = 1; j < FWD_STAGES; j++) shadow[j] <= shadow[j-1];
      fwd_sel   <= advance ? next_sel : '0;
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic        id_regwrite;
  logic        id_memread;
  logic [4:0]  id_rd;
  logic [14:0] id_src;
  logic [2:0]  id_src_used;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic [3:0]  stall_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // Small counter width so saturation is reachable in a short run.
  fwd_hazard_unit #(
    .NUM_SRC   (3),
    .FWD_STAGES(2),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .id_rd      (id_rd),
    .id_src     (id_src),
    .id_src_used(id_src_used),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sel(input int i);
    return fwd_sel[i*2 +: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] used);
    id_valid    = v;
    id_regwrite = rw;
    id_memread  = mr;
    id_rd       = rd;
    id_src      = {s2, s1, s0};
    id_src_used = used;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
  endtask

  task automatic drain();
    repeat (3) begin
      nop();
      tick();
    end
  endtask

  task automatic bump();
    exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_sel", fwd_sel, 0);
    chk("rst_cnt", stall_count, 0);
    #9;
    reset = 1'b0;
    tick();

    // ADD X1 then ADD reading Rn = X1: EX/MEM forward on src0 only
    drive(1, 1, 0, 5'd1, 5'd2, 5'd3, 5'd0, 3'b011);
    chk("a_stall0", stall, 0);
    tick();
    drive(1, 1, 0, 5'd5, 5'd1, 5'd4, 5'd0, 3'b011);
    chk("a_stall1", stall, 0);
    tick();
    chk("a_sel0", sel(0), 1);
    chk("a_sel1", sel(1), 0);
    chk("a_sel2", sel(2), 0);
    drain();

    // two writers of X1: nearest wins
    drive(1, 1, 0, 5'd1, 5'd2, 5'd3, 5'd0, 3'b011);
    tick();
    drive(1, 1, 0, 5'd1, 5'd4, 5'd5, 5'd0, 3'b011);
    tick();
    drive(1, 1, 0, 5'd9, 5'd1, 5'd0, 5'd0, 3'b001);
    tick();
    chk("b_nearest", sel(0), 1);
    drain();
    // only the two-ahead writer: MEM/WB forward
    drive(1, 1, 0, 5'd1, 5'd2, 5'd3, 5'd0, 3'b011);
    tick();
    nop();
    tick();
    drive(1, 1, 0, 5'd9, 5'd1, 5'd0, 5'd0, 3'b001);
    tick();
    chk("b_far", sel(0), 2);
    drain();

    // LDUR X2 then ADD reading Rm = X2: one stall, bubble, then MEM/WB forward
    drive(1, 1, 1, 5'd2, 5'd10, 5'd0, 5'd0, 3'b001);
    tick();
    drive(1, 1, 0, 5'd8, 5'd7, 5'd2, 5'd0, 3'b011);
    chk("c_stall", stall, 1);
    tick();
    bump();
    chk("c_bubble_sel", fwd_sel, 0);
    chk("c_stall_once", stall, 0);
    tick();
    chk("c_sel1", sel(1), 2);
    chk("c_cnt", stall_count, exp_cnt);
    drain();

    // store data from a load also stalls
    drive(1, 1, 1, 5'd3, 5'd10, 5'd0, 5'd0, 3'b001);
    tick();
    drive(1, 0, 0, 5'd0, 5'd9, 5'd9, 5'd3, 3'b111);
    chk("d_ld_st_stall", stall, 1);
    tick();
    bump();
    tick();
    chk("d_ld_st_cnt", stall_count, exp_cnt);
    drain();

    // ADD X3 then STUR reading Rd = X3
    drive(1, 1, 0, 5'd3, 5'd1, 5'd2, 5'd0, 3'b011);
    tick();
    drive(1, 0, 0, 5'd0, 5'd9, 5'd9, 5'd3, 3'b111);
    chk("d_st_stall", stall, 0);
    tick();
    chk("d_st_sel2", sel(2), 1);
    chk("d_st_sel0", sel(0), 0);
    drain();
    drive(1, 1, 0, 5'd3, 5'd1, 5'd2, 5'd0, 3'b011);
    tick();
    drive(1, 0, 0, 5'd0, 5'd9, 5'd9, 5'd3, 3'b011);
    tick();
    chk("d_unused_sel2", sel(2), 0);
    drain();

    // zero register: load to X31 then read X31
    drive(1, 1, 1, 5'd31, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    drive(1, 1, 0, 5'd8, 5'd31, 5'd31, 5'd31, 3'b111);
    chk("e_zr_stall", stall, 0);
    tick();
    chk("e_zr_sel", fwd_sel, 0);
    drain();

    // flush on a pending load-use: no stall, bubble, older load keeps shifting
    drive(1, 1, 1, 5'd4, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    flush = 1'b1;
    drive(1, 1, 0, 5'd8, 5'd4, 5'd0, 5'd0, 3'b001);
    chk("f_flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("f_flush_sel", fwd_sel, 0);
    drive(1, 1, 0, 5'd8, 5'd4, 5'd0, 5'd0, 3'b001);
    chk("f_after_stall", stall, 0);
    tick();
    chk("f_after_sel", sel(0), 2);
    chk("f_cnt", stall_count, exp_cnt);
    drain();

    // hold during a stall: shadow, fwd_sel and counter frozen
    drive(1, 1, 0, 5'd6, 5'd1, 5'd2, 5'd0, 3'b011);
    tick();
    drive(1, 1, 1, 5'd5, 5'd6, 5'd0, 5'd0, 3'b001);
    tick();
    chk("h_ld_sel", sel(0), 1);
    drive(1, 1, 0, 5'd8, 5'd5, 5'd0, 5'd0, 3'b001);
    chk("h_stall", stall, 1);
    hold = 1'b1;
    tick();
    chk("h_hold_stall", stall, 1);
    chk("h_hold_sel", sel(0), 1);
    chk("h_hold_cnt", stall_count, exp_cnt);
    hold = 1'b0;
    tick();
    bump();
    chk("h_rel_cnt", stall_count, exp_cnt);
    chk("h_rel_sel", fwd_sel, 0);
    tick();
    chk("h_fwd", sel(0), 2);
    drain();

    // chained LDUR X7,[X7]: one stall every two cycles until the counter saturates
    drive(1, 1, 1, 5'd7, 5'd7, 5'd0, 5'd0, 3'b001);
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      bump();
      tick();
    end
    chk("s_cnt_full", stall_count, 15);
    chk("s_stall", stall, 1);
    tick();
    bump();
    chk("s_cnt_sat", stall_count, exp_cnt);
    tick();
    chk("s_pre_rst_stall", stall, 1);
    chk("s_pre_rst_sel", sel(0), 2);

    // asynchronous reset mid-stall
    #2;
    reset = 1'b1;
    #1;
    chk("r_stall", stall, 0);
    chk("r_sel", fwd_sel, 0);
    chk("r_cnt", stall_count, 0);
    #2;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the CPU's combinational forwarding logic.
- Keeps its own shadow pipeline of in-flight destination tags: EX, MEM and deeper stages.
- Decides forwarding in the ID stage and presents the select values as registered outputs while the instruction is in EX.
- Detects load-use hazards, raises a one-cycle stall and inserts the bubble itself. Also supports flush, global hold and a stall performance counter.
- Sits between the decode stage and the EX operand muxes.

Parameters:
- REG_AW, 5: register index width.
- ZERO_REG, 31: hardwired-zero register index; never forwarded and never a hazard.
- NUM_SRC, 3: operand sources per instruction (Rn, Rm, store-data Rd).
- FWD_STAGES, 2: forwardable result stages after EX (1 = EX/MEM, 2 = MEM/WB, ...).
- SELW, $clog2(FWD_STAGES+1): width of each select field.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  global freeze; all state holds
- flush  in  1  kill the instruction in ID
- id_valid  in  1  ID slot holds a real instruction
- id_regwrite  in  1  ID instruction writes id_rd
- id_memread  in  1  ID instruction is a load
- id_rd  in  REG_AW  ID destination register
- id_src  in  NUM_SRC*REG_AW  ID source registers; source i is at [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-source read enable
- stall  out  1  combinational; freeze PC/IF-ID and bubble EX
- fwd_sel  out  NUM_SRC*SELW  registered; select per EX operand. 0 = register file, k = result from forward stage k
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (asynchronous): all shadow entries invalid, fwd_sel = 0, stall_count = 0. stall is then 0 because no entry is valid.
- Shadow entry j (0 = EX … FWD_STAGES-1) holds {valid, regwrite, memread, rd}.
- Entry j is "live" iff valid & regwrite & rd != ZERO_REG.
- Match for source i at entry j: live(j) & id_src_used[i] & id_valid & id_src[i] == rd(j).
- stall = id_valid & !flush & (a source i matches entry 0 & memread(0)).
  - Loads in deeper entries never stall.
  - Store data from a load is also a stall; no MEM-to-MEM path.
- Next select for source i = (smallest j with a match) + 1, else 0. The nearest producer wins.
- WB-stage writes are not tracked. The register file is write-through, so a WB producer is already visible.
- Each clock with hold = 0:
  - Entries shift: entry j+1 <= entry j.
  - Entry 0 <= ID tags when id_valid & !flush & !stall; otherwise entry 0 is an invalid bubble.
  - fwd_sel <= next selects when ID advances; otherwise fwd_sel <= 0.
- hold = 1: shadow, fwd_sel and stall_count hold. stall is still computed combinationally; the pipeline is frozen anyway.
- flush = 1 (hold = 0): ID is treated as invalid. stall is forced to 0. Older shadow entries continue to shift.
- hold and flush together: hold wins. The flush request must persist until hold deasserts.
- stall_count increments on each cycle with stall & !hold. It saturates at all-ones and does not wrap.
- No combinational path from ID inputs to fwd_sel. stall is the only combinational output.
- Reset asserted mid-stall drops stall immediately; the shadow is cleared.

Decomposition:
- Shared cpu_pkg holds:
  - REG_AW and ZERO_REG;
  - a packed struct shadow_tag_t {valid, regwrite, memread, rd};
  - fwd_sel encoding constants: FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2.
- One natural sub-module: fwd_src_match. Per source, it compares against all shadow entries and produces the priority-encoded select and a load-hazard bit. It is instantiated NUM_SRC times with a generate loop.

Test Plan:
- ADD X1 issued, next ADD reads Rn = X1 (defaults) -> stall = 0; next cycle fwd_sel[src0] = 1, others 0.
- X1 written by instructions two and one ahead, then read -> fwd_sel[src0] = 1 (nearest wins). With only the two-ahead writer -> 2.
- LDUR X2, then ADD reading Rm = X2:
  - stall = 1 for exactly one cycle; fwd_sel = 0 that cycle (bubble);
  - the following cycle fwd_sel[src1] = 2;
  - stall_count = 1.
- STUR reading Rd = X3 right after ADD X3 -> fwd_sel[src2] = 1. Same sequence with id_src_used[2] = 0 -> 0.
- Writer to X31, then reader of X31 -> fwd_sel = 0 and stall = 0. Load-use pending with flush = 1 -> stall = 0 and a bubble is inserted. hold = 1 during a stall -> state and counter frozen.
- Force stall_count to all-ones with repeated load-use pairs, then one more stall -> stays all-ones. Assert reset mid-stall -> stall = 0, fwd_sel = 0, count = 0 asynchronously.
